// File: rtl/frame_pixel_streamer.sv
// Raster frame reader: streams one frame from a synchronous RAM as valid/pixel
// beats with optional inter-row blanking and trailing zero flush rows.
module frame_pixel_streamer #(
    parameter int PIX_WIDTH    = 16,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int ADDR_WIDTH   = 19,
    parameter int HBLANK       = 2,
    parameter int FLUSH_ROWS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [PIX_WIDTH-1:0]  mem_rdata,
    output logic                  valid_out,
    output logic [PIX_WIDTH-1:0]  pixel_out,
    output logic                  sof,
    output logic                  eol
);

    localparam int ROWS  = IMAGE_HEIGHT + FLUSH_ROWS;
    localparam int COL_W = $clog2(IMAGE_WIDTH);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int BLK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] IMG_ROWS = ROW_W'(IMAGE_HEIGHT);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'((HBLANK > 0) ? HBLANK - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_HBLANK,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [BLK_W-1:0]      blk_q, blk_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic                  issue, zero_sel, issue_sof, issue_eol, row_end;

    logic                  s1_valid_q, s1_zero_q, s1_sof_q, s1_eol_q;
    logic                  valid_q, sof_q, eol_q;
    logic [PIX_WIDTH-1:0]  pixel_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        blk_d     = blk_q;
        addr_d    = addr_q;
        issue     = 1'b0;
        zero_sel  = 1'b0;
        mem_en    = 1'b0;
        done      = 1'b0;
        row_end   = (col_q == COL_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    col_d   = '0;
                    row_d   = '0;
                    blk_d   = '0;
                    addr_d  = '0;
                end
            end

            S_READ, S_FLUSH: begin
                issue    = 1'b1;
                zero_sel = (state_q == S_FLUSH);
                mem_en   = (state_q == S_READ);
                if (!row_end) begin
                    col_d = col_q + 1'b1;
                    if (state_q == S_READ) addr_d = addr_q + 1'b1;
                end else begin
                    col_d = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        row_d = row_q + 1'b1;
                        if (HBLANK > 0) begin
                            state_d = S_HBLANK;
                            blk_d   = '0;
                        end else if (row_d < IMG_ROWS) begin
                            state_d = S_READ;
                            addr_d  = addr_q + 1'b1;
                        end else begin
                            state_d = S_FLUSH;
                        end
                    end
                end
            end

            // addr holds the last issued address and only steps when the next read begins
            S_HBLANK: begin
                if (blk_q == BLK_LAST) begin
                    if (row_q < IMG_ROWS) begin
                        state_d = S_READ;
                        addr_d  = addr_q + 1'b1;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end

            S_DRAIN: begin
                if (!s1_valid_q && !valid_q) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign issue_sof = issue && !zero_sel && (row_q == '0) && (col_q == '0);
    assign issue_eol = issue && row_end;

    // NOTE: reset is synchronous, so it is only tested inside the clocked block.
    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            blk_q      <= '0;
            addr_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_sof_q   <= 1'b0;
            s1_eol_q   <= 1'b0;
            valid_q    <= 1'b0;
            pixel_q    <= '0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            blk_q      <= blk_d;
            addr_q     <= addr_d;
            s1_valid_q <= issue;
            s1_zero_q  <= zero_sel;
            s1_sof_q   <= issue_sof;
            s1_eol_q   <= issue_eol;
            valid_q    <= s1_valid_q;
            pixel_q    <= (s1_valid_q && !s1_zero_q) ? mem_rdata : '0;
            sof_q      <= s1_sof_q;
            eol_q      <= s1_eol_q;
        end
    end

    assign busy      = (state_q != S_IDLE) && !done;
    assign mem_addr  = addr_q;
    assign valid_out = valid_q;
    assign pixel_out = pixel_q;
    assign sof       = sof_q;
    assign eol       = eol_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Self-checking bench: two streamer configurations driven in lockstep and
// compared every cycle against a slot-arithmetic reference model.
module tb_frame_pixel_streamer;

    localparam int PW = 16;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start;
    logic          a_busy, a_done, a_mem_en, a_valid, a_sof, a_eol;
    logic [AW-1:0] a_addr;
    logic [PW-1:0] a_rdata = '0, a_pix;
    logic          b_busy, b_done, b_mem_en, b_valid, b_sof, b_eol;
    logic [AW-1:0] b_addr;
    logic [PW-1:0] b_rdata = '0, b_pix;

    logic [PW-1:0] ram [0:15];

    always @(posedge clk) begin
        if (a_mem_en) a_rdata <= ram[a_addr];
        if (b_mem_en) b_rdata <= ram[b_addr];
    end

    frame_pixel_streamer #(
        .PIX_WIDTH(PW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_WIDTH(AW),
        .HBLANK(2), .FLUSH_ROWS(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(a_busy), .done(a_done),
        .mem_en(a_mem_en), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .valid_out(a_valid), .pixel_out(a_pix), .sof(a_sof), .eol(a_eol)
    );

    frame_pixel_streamer #(
        .PIX_WIDTH(PW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .ADDR_WIDTH(AW),
        .HBLANK(0), .FLUSH_ROWS(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(b_busy), .done(b_done),
        .mem_en(b_mem_en), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .valid_out(b_valid), .pixel_out(b_pix), .sof(b_sof), .eol(b_eol)
    );

    typedef struct {
        bit busy, done, mem_en, valid, sof, eol;
        int addr, pixel;
    } obs_t;

    typedef struct {
        int cyc;
        bit mem_en, valid;
        int pixel;
        bit sof, eol, done, busy;
    } vec_t;

    int   n_total = 0, n_pass = 0, cyc = 0;
    bit   cmp_on = 1'b0;
    bit   a_act = 1'b0, b_act = 1'b0;
    int   a_k = 0, b_k = 0, a_held = 0, b_held = 0;
    obs_t log_a [64];
    obs_t log_b [64];
    vec_t tbl   [17];

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    // Frame as a timeline of slots: slot j (j = k-1 cycles after start) sits in
    // row j/(W+HB) at column j%(W+HB); columns >= W are blanking.
    function automatic obs_t model(int w, int h, int hb, int f, bit act, int k, int held);
        obs_t e;
        int rows, dn, per, j, r, c;
        e      = '{default: 0};
        e.addr = held;
        if (act) begin
            rows   = h + f;
            per    = w + hb;
            dn     = 1 + rows * w + (rows - 1) * hb + 2;
            e.done = (k == dn);
            e.busy = (k < dn);
            j = k - 1;
            if (j >= 0 && j / per < rows && j % per < w && j / per < h) begin
                e.mem_en = 1'b1;
                e.addr   = (j / per) * w + (j % per);
            end
            j = k - 3;
            if (j >= 0 && j / per < rows && j % per < w) begin
                r       = j / per;
                c       = j % per;
                e.valid = 1'b1;
                e.pixel = (r < h) ? int'(ram[r * w + c]) : 0;
                e.sof   = (r == 0 && c == 0);
                e.eol   = (c == w - 1);
            end
        end
        return e;
    endfunction

    task automatic adv(obs_t e, bit rs, bit st, inout bit act, inout int k, inout int held);
        if (rs) begin
            act  = 1'b0;
            held = 0;
        end else begin
            if (e.mem_en) held = e.addr;
            if (act) begin
                if (e.done) act = 1'b0;
                else k++;
            end else if (st) begin
                act = 1'b1;
                k   = 1;
            end
        end
    endtask

    task automatic cmp(string tag, obs_t e, obs_t o);
        check({tag, ".busy"},   o.busy,   e.busy);
        check({tag, ".done"},   o.done,   e.done);
        check({tag, ".mem_en"}, o.mem_en, e.mem_en);
        check({tag, ".addr"},   o.addr,   e.addr);
        check({tag, ".valid"},  o.valid,  e.valid);
        check({tag, ".pixel"},  o.pixel,  e.pixel);
        check({tag, ".sof"},    o.sof,    e.sof);
        check({tag, ".eol"},    o.eol,    e.eol);
    endtask

    task automatic tick(bit st, bit rs);
        obs_t ea, eb, oa, ob;
        start = st;
        rst   = rs;
        @(negedge clk);
        oa = '{busy: a_busy, done: a_done, mem_en: a_mem_en, valid: a_valid,
               sof: a_sof, eol: a_eol, addr: int'(a_addr), pixel: int'(a_pix)};
        ob = '{busy: b_busy, done: b_done, mem_en: b_mem_en, valid: b_valid,
               sof: b_sof, eol: b_eol, addr: int'(b_addr), pixel: int'(b_pix)};
        ea = model(W, H, 2, 1, a_act, a_k, a_held);
        eb = model(W, H, 0, 0, b_act, b_k, b_held);
        if (cmp_on) begin
            cmp("a", ea, oa);
            cmp("b", eb, ob);
        end
        if (cyc < 64) begin
            log_a[cyc] = oa;
            log_b[cyc] = ob;
        end
        @(posedge clk);
        adv(ea, rs, st, a_act, a_k, a_held);
        adv(eb, rs, st, b_act, b_k, b_held);
        #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = PW'(i + 1);

        //            cyc men val pix sof eol done busy
        tbl[0]  = '{ 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{ 1, 1, 0,  0, 0, 0, 0, 1};
        tbl[2]  = '{ 2, 1, 0,  0, 0, 0, 0, 1};
        tbl[3]  = '{ 3, 1, 1,  1, 1, 0, 0, 1};
        tbl[4]  = '{ 4, 1, 1,  2, 0, 0, 0, 1};
        tbl[5]  = '{ 5, 0, 1,  3, 0, 0, 0, 1};
        tbl[6]  = '{ 6, 0, 1,  4, 0, 1, 0, 1};
        tbl[7]  = '{ 7, 1, 0,  0, 0, 0, 0, 1};
        tbl[8]  = '{ 9, 1, 1,  5, 0, 0, 0, 1};
        tbl[9]  = '{12, 0, 1,  8, 0, 1, 0, 1};
        tbl[10] = '{13, 1, 0,  0, 0, 0, 0, 1};
        tbl[11] = '{18, 0, 1, 12, 0, 1, 0, 1};
        tbl[12] = '{19, 0, 0,  0, 0, 0, 0, 1};
        tbl[13] = '{21, 0, 1,  0, 0, 0, 0, 1};
        tbl[14] = '{24, 0, 1,  0, 0, 1, 0, 1};
        tbl[15] = '{25, 0, 0,  0, 0, 0, 1, 0};
        tbl[16] = '{26, 0, 0,  0, 0, 0, 0, 0};

        // Reset: the first cycle precedes any clock edge, so it is not compared.
        tick(1'b0, 1'b1);
        cmp_on = 1'b1;
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        check("rst.busy",   log_a[2].busy,   0);
        check("rst.done",   log_a[2].done,   0);
        check("rst.mem_en", log_a[2].mem_en, 0);
        check("rst.addr",   log_a[2].addr,   0);
        check("rst.valid",  log_a[2].valid,  0);
        check("rst.pixel",  log_a[2].pixel,  0);
        check("rst.sof",    log_a[2].sof,    0);
        check("rst.eol",    log_a[2].eol,    0);

        // Nominal frame on A, no-blank/no-flush frame on B.
        cyc = 0;
        repeat (31) tick(cyc == 0, 1'b0);
        foreach (tbl[i]) begin
            obs_t o;
            o = log_a[tbl[i].cyc];
            check("tbl.mem_en", o.mem_en, tbl[i].mem_en);
            check("tbl.valid",  o.valid,  tbl[i].valid);
            check("tbl.pixel",  o.pixel,  tbl[i].pixel);
            check("tbl.sof",    o.sof,    tbl[i].sof);
            check("tbl.eol",    o.eol,    tbl[i].eol);
            check("tbl.done",   o.done,   tbl[i].done);
            check("tbl.busy",   o.busy,   tbl[i].busy);
        end
        for (int c = 3; c <= 14; c++) begin
            check("nb.valid", log_b[c].valid, 1);
            check("nb.pixel", log_b[c].pixel, c - 2);
        end
        for (int c = 1; c <= 12; c++) check("nb.addr", log_b[c].addr, c - 1);
        check("nb.pre_valid", log_b[2].valid, 0);
        check("nb.done",      log_b[15].done, 1);
        check("nb.post",      log_b[15].valid, 0);
        check("nb.eol_mid",   log_b[6].eol, 1);

        // Start while busy and in the done cycle are ignored; one cycle later is taken.
        cyc = 0;
        repeat (56) tick(cyc == 0 || cyc == 5 || cyc == 25 || cyc == 26, 1'b0);
        check("sb.done25",  log_a[25].done,  1);
        check("sb.busy26",  log_a[26].busy,  0);
        check("sb.busy27",  log_a[27].busy,  1);
        check("sb.val28",   log_a[28].valid, 0);
        check("sb.val29",   log_a[29].valid, 1);
        check("sb.pix29",   log_a[29].pixel, 1);
        check("sb.sof29",   log_a[29].sof,   1);
        check("sb.done51",  log_a[51].done,  1);

        // Reset mid-frame aborts; restart replays from pixel 1.
        cyc = 0;
        repeat (45) tick(cyc == 0 || cyc == 12, cyc == 10);
        for (int c = 11; c <= 14; c++) begin
            check("mr.valid", log_a[c].valid, 0);
            check("mr.done",  log_a[c].done,  0);
            check("mr.eol",   log_a[c].eol,   0);
        end
        check("mr.busy11",  log_a[11].busy,   0);
        check("mr.men12",   log_a[12].mem_en, 0);
        check("mr.men13",   log_a[13].mem_en, 1);
        check("mr.val15",   log_a[15].valid,  1);
        check("mr.pix15",   log_a[15].pixel,  1);
        check("mr.sof15",   log_a[15].sof,    1);

        // Random starts and resets with random RAM contents; both DUTs idle here.
        for (int i = 0; i < 16; i++) ram[i] = PW'($urandom);
        repeat (2000) tick($urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        repeat (60) tick(1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
